// File: rtl/cfg_seq_if.sv
// cfg_seq_if: register-write handshake between cfg_seq and the SCCB master.
// Signals: o_wr_valid/o_wr_reg/o_wr_val (request), i_wr_ready (accept),
//          i_wr_done (bus write finished), i_wr_nack (CFG_NACK_EN only).
// Names are from the sequencer's point of view.
interface cfg_seq_if #(
    parameter int REG_W = 8
) ();
    logic             o_wr_valid;
    logic             i_wr_ready;
    logic [REG_W-1:0] o_wr_reg;
    logic [REG_W-1:0] o_wr_val;
    logic             i_wr_done;
`ifdef CFG_NACK_EN
    logic             i_wr_nack;

    modport master (
        output o_wr_valid, o_wr_reg, o_wr_val,
        input  i_wr_ready, i_wr_done, i_wr_nack
    );
    modport slave (
        input  o_wr_valid, o_wr_reg, o_wr_val,
        output i_wr_ready, i_wr_done, i_wr_nack
    );
`else
    modport master (
        output o_wr_valid, o_wr_reg, o_wr_val,
        input  i_wr_ready, i_wr_done
    );
    modport slave (
        input  o_wr_valid, o_wr_reg, o_wr_val,
        output i_wr_ready, i_wr_done
    );
`endif
endinterface

// File: rtl/cfg_seq.sv
// cfg_seq: camera configuration sequencer. Walks a {reg,val} table from
// address 0 (1-cycle read latency), handles END/DELAY markers and issues
// register writes to the SCCB master, waiting for each write to finish.
// Ports: i_clk, i_rstn (sync, active-low), i_start, o_busy, o_done,
//        o_rom_addr, i_rom_data, wr_if (cfg_seq_if.master),
//        o_err (CFG_NACK_EN only).
// Optional macro CFG_NACK_EN: NACK retry with MAX_RETRY retries and o_err.
module cfg_seq #(
    parameter int ADDR_W     = 8,
    parameter int ROM_DEPTH  = 256,
    parameter int REG_W      = 8,
    parameter int DELAY_UNIT = 100000,
    parameter int MAX_RETRY  = 3
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,
    output logic [ADDR_W-1:0]   o_rom_addr,
    input  logic [2*REG_W-1:0]  i_rom_data,
`ifdef CFG_NACK_EN
    output logic                o_err,
`endif
    cfg_seq_if.master           wr_if
);

    if (ROM_DEPTH > 2**ADDR_W || DELAY_UNIT < 1 || MAX_RETRY < 0)
    begin : g_bad_cfg
        $error("cfg_seq: illegal parameter combination");
    end

    // Wide enough for the full val*DELAY_UNIT product.
    localparam int CW = REG_W + $clog2(DELAY_UNIT) + 1;
    localparam logic [CW-1:0] DU_W = CW'(DELAY_UNIT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WRITE,
        S_WAIT,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_busy;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_wr_valid;
    logic [REG_W-1:0]  r_wr_reg;
    logic [REG_W-1:0]  r_wr_val;
    logic [CW-1:0]     r_dly_cnt;

    logic [REG_W-1:0]  w_reg;
    logic [REG_W-1:0]  w_val;
    logic              w_is_end;
    logic              w_is_dly;
    logic              w_last;
    logic [CW-1:0]     w_dly_load;

`ifdef CFG_NACK_EN
    localparam int RTW = $clog2(MAX_RETRY + 2);
    localparam logic [RTW-1:0] RETRY_MAX = RTW'(MAX_RETRY);

    logic [RTW-1:0] r_retry;
    logic           r_err;
    logic           w_nack;
    logic           w_retry_out;

    assign w_nack      = wr_if.i_wr_done && wr_if.i_wr_nack;
    assign w_retry_out = (r_retry == RETRY_MAX);
    assign o_err       = r_err;
`endif

    assign w_reg      = i_rom_data[2*REG_W-1:REG_W];
    assign w_val      = i_rom_data[REG_W-1:0];
    assign w_is_end   = (&w_reg) && (&w_val);
    assign w_is_dly   = (&w_reg) && !(&w_val);
    assign w_last     = (r_rom_addr == LAST_ADDR);
    assign w_dly_load = CW'(w_val) * DU_W;

    assign o_busy           = r_busy;
    assign o_done           = (r_state == S_DONE);
    assign o_rom_addr       = r_rom_addr;
    assign wr_if.o_wr_valid = r_wr_valid;
    assign wr_if.o_wr_reg   = r_wr_reg;
    assign wr_if.o_wr_val   = r_wr_val;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (i_start) w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (w_is_end)
                    w_next = S_DONE;
                else if (w_is_dly)
                    w_next = (w_val == '0) ? S_NEXT : S_DELAY;
                else
                    w_next = S_WRITE;
            end
            S_WRITE:  if (wr_if.i_wr_ready) w_next = S_WAIT;
            S_WAIT: begin
`ifdef CFG_NACK_EN
                if (w_nack)
                    w_next = w_retry_out ? S_ERR : S_DECODE;
                else if (wr_if.i_wr_done)
                    w_next = S_NEXT;
`else
                if (wr_if.i_wr_done) w_next = S_NEXT;
`endif
            end
            S_DELAY:  if (r_dly_cnt == CW'(1)) w_next = S_NEXT;
            S_NEXT:   w_next = w_last ? S_DONE : S_FETCH;
            S_DONE:   w_next = S_IDLE;
            S_ERR:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_busy     <= 1'b0;
            r_rom_addr <= '0;
            r_wr_valid <= 1'b0;
            r_wr_reg   <= '0;
            r_wr_val   <= '0;
            r_dly_cnt  <= '0;
`ifdef CFG_NACK_EN
            r_retry    <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_rom_addr <= '0;
                        r_busy     <= 1'b1;
`ifdef CFG_NACK_EN
                        r_retry    <= '0;
                        r_err      <= 1'b0;
`endif
                    end
                end
                S_DECODE: begin
                    if (w_is_dly) begin
                        r_dly_cnt <= w_dly_load;
                    end else if (!w_is_end) begin
                        r_wr_reg   <= w_reg;
                        r_wr_val   <= w_val;
                        r_wr_valid <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (wr_if.i_wr_ready) r_wr_valid <= 1'b0;
                end
`ifdef CFG_NACK_EN
                S_WAIT: begin
                    if (w_nack && !w_retry_out) r_retry <= r_retry + 1'b1;
                end
`endif
                S_DELAY: r_dly_cnt <= r_dly_cnt - 1'b1;
                S_NEXT: begin
`ifdef CFG_NACK_EN
                    r_retry <= '0;
`endif
                    if (!w_last) r_rom_addr <= r_rom_addr + 1'b1;
                end
                S_DONE: r_busy <= 1'b0;
                S_ERR: begin
                    r_busy <= 1'b0;
`ifdef CFG_NACK_EN
                    r_err  <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_seq.sv
// tb_cfg_seq: scoreboard bench for cfg_seq with directed tables.
// Expected writes are queued by the stimulus and popped by the monitor.
module tb_cfg_seq;
    localparam int AW = 8;
    localparam int DEPTH = 4;
    localparam int RW = 8;
    localparam int DU = 4;
    localparam int MR = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
`ifdef CFG_NACK_EN
    logic          err;
    logic          nack_mode = 1'b0;
`endif

    cfg_seq_if #(.REG_W(RW)) bus ();

    logic [15:0] mem [0:255];
    logic [15:0] exp_q [$];
    int rise_q [$];
    int wdone_q [$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_done = 0;

    cfg_seq #(
        .ADDR_W(AW), .ROM_DEPTH(DEPTH), .REG_W(RW),
        .DELAY_UNIT(DU), .MAX_RETRY(MR)
    ) dut (
        .i_clk(clk),
        .i_rstn(rstn),
        .i_start(start),
        .o_busy(busy),
        .o_done(done),
        .o_rom_addr(rom_addr),
        .i_rom_data(rom_data),
`ifdef CFG_NACK_EN
        .o_err(err),
`endif
        .wr_if(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= mem[rom_addr];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    function automatic int qget(input int q [$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Monitor: scoreboard pop on accept, hold check while stalled.
    initial begin
        logic pv = 1'b0;
        logic pstall = 1'b0;
        logic [15:0] pd = '0;
        logic [15:0] d;
        forever begin
            @(posedge clk);
            d = {bus.o_wr_reg, bus.o_wr_val};
            if (pstall && rstn) begin
                chk("hold_valid", 32'(bus.o_wr_valid), 32'd1);
                chk("hold_data", 32'(d), 32'(pd));
            end
            if (bus.o_wr_valid && !pv) rise_q.push_back(cyc);
            if (bus.o_wr_valid && bus.i_wr_ready && rstn) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got %h want none", d);
                end else begin
                    chk("wr_data", 32'(d), 32'(exp_q.pop_front()));
                end
            end
            if (done) n_done++;
            pv = bus.o_wr_valid;
            pstall = rstn && bus.o_wr_valid && !bus.i_wr_ready;
            pd = d;
        end
    end

    // SCCB master model: done pulse two edges after the accept edge.
    initial begin
        int cnt = 0;
        logic acc;
        bus.i_wr_done = 1'b0;
`ifdef CFG_NACK_EN
        bus.i_wr_nack = 1'b0;
`endif
        forever begin
            @(posedge clk);
            acc = bus.o_wr_valid && bus.i_wr_ready && rstn;
            #1;
            bus.i_wr_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.i_wr_done = 1'b1;
`ifdef CFG_NACK_EN
                    bus.i_wr_nack = nack_mode;
`endif
                    wdone_q.push_back(cyc);
                end
            end
            if (acc) cnt = 2;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
        for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
        mem[0] = a;
        mem[1] = b;
        mem[2] = c;
        mem[3] = d;
        rise_q.delete();
        wdone_q.delete();
    endtask

    task automatic go(output int k);
        start = 1'b1;
        k = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int n0);
        int i = 0;
        while (n_done == n0 && i < 300) begin
            tick(1);
            i++;
        end
        if (n_done == n0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no o_done want o_done", nm);
        end
    endtask

    task automatic wait_valid(input string nm);
        int i = 0;
        while (!bus.o_wr_valid && i < 100) begin
            tick(1);
            i++;
        end
        if (!bus.o_wr_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no valid want valid", nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n0;
        int a0;
        bus.i_wr_ready = 1'b1;
        load(16'h1280, 16'h1180, 16'hFFFF, 16'hFFFF);
        tick(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_valid", 32'(bus.o_wr_valid), 32'd0);
        chk("rst_regval", 32'({bus.o_wr_reg, bus.o_wr_val}), 32'd0);
`ifdef CFG_NACK_EN
        chk("rst_err", 32'(err), 32'd0);
`endif
        rstn = 1'b1;
        tick(2);

        // Two writes then END.
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1180);
        n0 = n_done;
        a0 = n_acc;
        go(k);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done("t1", n0);
        tick(1);
        chk("t1_start_lat", 32'(qget(rise_q, 0)), 32'(k + 3));
        chk("t1_done_lat", 32'(qget(rise_q, 1)), 32'(qget(wdone_q, 0) + 4));
        chk("t1_nacc", 32'(n_acc - a0), 32'd2);
        chk("t1_ndone", 32'(n_done - n0), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_addr", 32'(rom_addr), 32'd2);
        chk("t1_q", 32'(exp_q.size()), 32'd0);

        // Delay of 3*4 cycles.
        load(16'hFF03, 16'h3A04, 16'hFFFF, 16'hFFFF);
        exp_q.push_back(16'h3A04);
        n0 = n_done;
        go(k);
        wait_done("t2", n0);
        tick(1);
        chk("t2_dly_lat", 32'(qget(rise_q, 0)), 32'(k + 18));
        chk("t2_nrise", 32'(rise_q.size()), 32'd1);
        chk("t2_q", 32'(exp_q.size()), 32'd0);

        // Zero-length delay.
        load(16'hFF00, 16'h40D0, 16'hFFFF, 16'hFFFF);
        exp_q.push_back(16'h40D0);
        n0 = n_done;
        go(k);
        wait_done("t3", n0);
        tick(1);
        chk("t3_dly0_lat", 32'(qget(rise_q, 0)), 32'(k + 6));
        chk("t3_q", 32'(exp_q.size()), 32'd0);

        // Backpressure: ready low for 5 valid cycles.
        load(16'h55AA, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        bus.i_wr_ready = 1'b0;
        exp_q.push_back(16'h55AA);
        n0 = n_done;
        a0 = n_acc;
        go(k);
        wait_valid("t4");
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_valid", 32'(bus.o_wr_valid), 32'd1);
            chk("t4_stall_data", 32'({bus.o_wr_reg, bus.o_wr_val}),
                32'h55AA);
            tick(1);
        end
        bus.i_wr_ready = 1'b1;
        wait_done("t4", n0);
        tick(1);
        chk("t4_nacc", 32'(n_acc - a0), 32'd1);
        chk("t4_q", 32'(exp_q.size()), 32'd0);

        // No end marker: stop after ROM_DEPTH entries; start while busy.
        load(16'h0101, 16'h0202, 16'h0303, 16'h0404);
        for (int i = 1; i <= 4; i++) exp_q.push_back(16'(i * 16'h0101));
        n0 = n_done;
        a0 = n_acc;
        go(k);
        tick(6);
        go(k);
        chk("t5_busy_mid", 32'(busy), 32'd1);
        wait_done("t5", n0);
        tick(20);
        chk("t5_nacc", 32'(n_acc - a0), 32'd4);
        chk("t5_ndone", 32'(n_done - n0), 32'd1);
        chk("t5_addr", 32'(rom_addr), 32'd3);
        chk("t5_busy_end", 32'(busy), 32'd0);
        chk("t5_q", 32'(exp_q.size()), 32'd0);

        // Reset during WRITE, then replay from address 0.
        load(16'h1280, 16'h1180, 16'hFFFF, 16'hFFFF);
        bus.i_wr_ready = 1'b0;
        exp_q.push_back(16'h1280);
        go(k);
        wait_valid("t6");
        rstn = 1'b0;
        tick(1);
        chk("t6_rst_valid", 32'(bus.o_wr_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_addr", 32'(rom_addr), 32'd0);
        rstn = 1'b1;
        exp_q.delete();
        bus.i_wr_ready = 1'b1;
        tick(1);
        rise_q.delete();
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1180);
        n0 = n_done;
        a0 = n_acc;
        go(k);
        wait_done("t6", n0);
        tick(1);
        chk("t6_lat", 32'(qget(rise_q, 0)), 32'(k + 3));
        chk("t6_nacc", 32'(n_acc - a0), 32'd2);
        chk("t6_q", 32'(exp_q.size()), 32'd0);

`ifdef CFG_NACK_EN
        // NACK on every write of entry 0: 1 issue + 2 retries, then ERR.
        load(16'h1280, 16'h1180, 16'hFFFF, 16'hFFFF);
        nack_mode = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(16'h1280);
        n0 = n_done;
        a0 = n_acc;
        go(k);
        for (int i = 0; i < 200 && !err; i++) tick(1);
        tick(10);
        chk("t7_err", 32'(err), 32'd1);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_ndone", 32'(n_done - n0), 32'd0);
        chk("t7_nacc", 32'(n_acc - a0), 32'd3);
        chk("t7_q", 32'(exp_q.size()), 32'd0);
        nack_mode = 1'b0;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1180);
        go(k);
        chk("t7_err_clr", 32'(err), 32'd0);
        wait_done("t7", n0);
        tick(1);
        chk("t7_q2", 32'(exp_q.size()), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
